// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, FSM state type and datapath select codes for the
// multi-cycle control unit.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_NOR  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_SLT  = 6'h05;
    localparam logic [5:0] OP_MUL  = 6'h06;
    localparam logic [5:0] OP_ADDI = 6'h07;
    localparam logic [5:0] OP_SUBI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h09;
    localparam logic [5:0] OP_ORI  = 6'h0A;
    localparam logic [5:0] OP_SLTI = 6'h0B;
    localparam logic [5:0] OP_LUI  = 6'h0C;
    localparam logic [5:0] OP_LW   = 6'h0D;
    localparam logic [5:0] OP_LH   = 6'h0E;
    localparam logic [5:0] OP_LB   = 6'h0F;
    localparam logic [5:0] OP_SW   = 6'h10;
    localparam logic [5:0] OP_SH   = 6'h11;
    localparam logic [5:0] OP_SB   = 6'h12;
    localparam logic [5:0] OP_BEQ  = 6'h13;
    localparam logic [5:0] OP_BNEQ = 6'h14;
    localparam logic [5:0] OP_BGEZ = 6'h15;
    localparam logic [5:0] OP_J    = 6'h16;
    localparam logic [5:0] OP_JAL  = 6'h17;
    localparam logic [5:0] OP_JR   = 6'h18;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_NOR = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_MUL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode decode: instruction class, ALU operation and
// memory access size.
module opcode_class
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic       is_rtype_o,
    output logic       is_itype_alu_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       is_branch_o,
    output logic       is_jump_o,
    output logic       illegal_o,
    output logic [3:0] alu_op_o,
    output logic [1:0] mem_size_o
);

    always_comb begin
        is_rtype_o     = 1'b0;
        is_itype_alu_o = 1'b0;
        is_load_o      = 1'b0;
        is_store_o     = 1'b0;
        is_branch_o    = 1'b0;
        is_jump_o      = 1'b0;
        illegal_o      = 1'b0;
        alu_op_o       = ALU_ADD;
        mem_size_o     = SIZE_WORD;
        case (opcode_i)
            OP_ADD:  begin is_rtype_o = 1'b1; alu_op_o = ALU_ADD; end
            OP_SUB:  begin is_rtype_o = 1'b1; alu_op_o = ALU_SUB; end
            OP_AND:  begin is_rtype_o = 1'b1; alu_op_o = ALU_AND; end
            OP_NOR:  begin is_rtype_o = 1'b1; alu_op_o = ALU_NOR; end
            OP_OR:   begin is_rtype_o = 1'b1; alu_op_o = ALU_OR;  end
            OP_SLT:  begin is_rtype_o = 1'b1; alu_op_o = ALU_SLT; end
            OP_MUL:  begin is_rtype_o = 1'b1; alu_op_o = ALU_MUL; end
            OP_ADDI: begin is_itype_alu_o = 1'b1; alu_op_o = ALU_ADD; end
            OP_SUBI: begin is_itype_alu_o = 1'b1; alu_op_o = ALU_SUB; end
            OP_ANDI: begin is_itype_alu_o = 1'b1; alu_op_o = ALU_AND; end
            OP_ORI:  begin is_itype_alu_o = 1'b1; alu_op_o = ALU_OR;  end
            OP_SLTI: begin is_itype_alu_o = 1'b1; alu_op_o = ALU_SLT; end
            OP_LUI:  begin is_itype_alu_o = 1'b1; alu_op_o = ALU_LUI; end
            OP_LW:   begin is_load_o  = 1'b1; mem_size_o = SIZE_WORD; end
            OP_LH:   begin is_load_o  = 1'b1; mem_size_o = SIZE_HALF; end
            OP_LB:   begin is_load_o  = 1'b1; mem_size_o = SIZE_BYTE; end
            OP_SW:   begin is_store_o = 1'b1; mem_size_o = SIZE_WORD; end
            OP_SH:   begin is_store_o = 1'b1; mem_size_o = SIZE_HALF; end
            OP_SB:   begin is_store_o = 1'b1; mem_size_o = SIZE_BYTE; end
            OP_BEQ, OP_BNEQ, OP_BGEZ: begin
                is_branch_o = 1'b1;
                alu_op_o    = ALU_SUB;
            end
            OP_J, OP_JAL, OP_JR: is_jump_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back
// for the datapath and counts retired instructions.
//
//  state     | meaning
//  ----------+-----------------------------------------------------
//  ST_FETCH  | read instruction word, load IR and PC+1 on mem_ready
//  ST_DECODE | latch opcode; jumps finish here, illegal -> ST_TRAP
//  ST_EXEC   | ALU operation; branches resolve and finish here
//  ST_MEM    | load/store handshake, held until mem_ready
//  ST_WB     | register file write-back
//  ST_TRAP   | illegal opcode seen; idle until reset
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             neg,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_size,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             link,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       retire_s, taken_s;
    logic       mem_read_s, mem_write_s, ir_write_s, pc_write_s;
    logic       alu_src_imm_s, reg_write_s, mem_to_reg_s, link_s;
    logic [1:0] mem_size_s, pc_src_s;
    logic [3:0] alu_op_s;

    logic [5:0] cls_opcode;
    logic       cls_rtype, cls_itype, cls_load, cls_store;
    logic       cls_branch, cls_jump, cls_illegal;
    logic [3:0] cls_alu_op;
    logic [1:0] cls_mem_size;

    // Decode the raw IR opcode while in DECODE, the latched copy afterwards.
    assign cls_opcode = (state_q == ST_DECODE) ? opcode : opcode_q;

    opcode_class u_opcode_class (
        .opcode_i       (cls_opcode),
        .is_rtype_o     (cls_rtype),
        .is_itype_alu_o (cls_itype),
        .is_load_o      (cls_load),
        .is_store_o     (cls_store),
        .is_branch_o    (cls_branch),
        .is_jump_o      (cls_jump),
        .illegal_o      (cls_illegal),
        .alu_op_o       (cls_alu_op),
        .mem_size_o     (cls_mem_size)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        illegal_d     = illegal_q;
        retire_s      = 1'b0;
        taken_s       = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        mem_size_s    = SIZE_BYTE;
        ir_write_s    = 1'b0;
        pc_write_s    = 1'b0;
        pc_src_s      = PC_INC;
        alu_op_s      = ALU_ADD;
        alu_src_imm_s = 1'b0;
        reg_write_s   = 1'b0;
        mem_to_reg_s  = 1'b0;
        link_s        = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read_s = 1'b1;
                mem_size_s = SIZE_WORD;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    pc_src_s   = PC_INC;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                opcode_d = opcode;
                if (cls_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else if (cls_jump) begin
                    pc_write_s  = 1'b1;
                    pc_src_s    = (opcode == OP_JR) ? PC_REG : PC_JUMP;
                    reg_write_s = (opcode == OP_JAL);
                    link_s      = (opcode == OP_JAL);
                    retire_s    = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls_rtype || cls_itype) begin
                    alu_op_s      = cls_alu_op;
                    alu_src_imm_s = cls_itype;
                    state_d       = ST_WB;
                end else if (cls_load || cls_store) begin
                    alu_op_s      = ALU_ADD;
                    alu_src_imm_s = 1'b1;
                    state_d       = ST_MEM;
                end else if (cls_branch) begin
                    case (opcode_q)
                        OP_BEQ:  taken_s = zero;
                        OP_BNEQ: taken_s = !zero;
                        OP_BGEZ: taken_s = !neg;
                        default: taken_s = 1'b0;
                    endcase
                    alu_op_s   = cls_alu_op;
                    pc_write_s = taken_s;
                    pc_src_s   = taken_s ? PC_BRANCH : PC_INC;
                    retire_s   = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_read_s  = cls_load;
                mem_write_s = cls_store;
                mem_size_s  = cls_mem_size;
                if (mem_ready) begin
                    retire_s = cls_store;
                    state_d  = cls_load ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = cls_load;
                retire_s     = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase

        retired_d = retire_s ? retired_q + CNT_W'(1) : retired_q;
    end

    // Everything is held quiet while reset is asserted, including mid-handshake.
    assign mem_read    = rst_n & mem_read_s;
    assign mem_write   = rst_n & mem_write_s;
    assign mem_size    = rst_n ? mem_size_s : '0;
    assign ir_write    = rst_n & ir_write_s;
    assign pc_write    = rst_n & pc_write_s;
    assign pc_src      = rst_n ? pc_src_s : '0;
    assign alu_op      = rst_n ? alu_op_s : '0;
    assign alu_src_imm = rst_n & alu_src_imm_s;
    assign reg_write   = rst_n & reg_write_s;
    assign mem_to_reg  = rst_n & mem_to_reg_s;
    assign link        = rst_n & link_s;
    assign illegal     = rst_n & illegal_q;
    assign retired     = rst_n ? retired_q : '0;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit that sequences the 32-bit datapath core through fetch, decode, execute, memory and write-back, one instruction at a time. It decodes the 6-bit opcode field (25 instructions, 0x00–0x18) into per-state datapath strobes. It handles a ready/request memory handshake for fetch and load/store, and counts retired instructions. It sits beside the datapath inside the core and replaces its hard-wired single-cycle control.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- opcode  in  6  instruction opcode from datapath IR; valid from DECODE onward
- zero  in  1  ALU result == 0
- neg  in  1  ALU result bit 31
- mem_ready  in  1  memory completes the current read/write this cycle
- mem_read  out  1  memory read request (fetch or load)
- mem_write  out  1  memory write request (store)
- mem_size  out  2  0 byte, 1 half, 2 word
- ir_write  out  1  load IR from memory data
- pc_write  out  1  update PC
- pc_src  out  2  0 PC+1, 1 branch target, 2 jump target, 3 register (JR)
- alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 NOR, 4 OR, 5 SLT, 6 MUL, 7 LUI
- alu_src_imm  out  1  ALU B operand = immediate
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back data from memory
- link  out  1  write PC+1 to r31 (JAL)
- illegal  out  1  sticky: opcode > 0x18 decoded
- retired  out  CNT_W  instructions completed

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: mem_read=1, mem_size=2. Hold until mem_ready. On the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, then -> DECODE.
- DECODE: register opcode into opcode_q.
  - J: pc_write, pc_src=2, -> FETCH.
  - JAL: pc_write, pc_src=2, reg_write, link, -> FETCH.
  - JR: pc_write, pc_src=3, -> FETCH.
  - opcode > 0x18: set illegal, -> TRAP.
  - All other opcodes -> EXEC.
- EXEC:
  - R-type ADD/SUB/AND/NOR/OR/SLT/MUL: alu_op from opcode, alu_src_imm=0, -> WB.
  - ADDI/SUBI/ANDI/ORI/SLTI/LUI: matching alu_op, alu_src_imm=1, -> WB.
  - LB/LH/LW/SB/SH/SW: alu_op=ADD, alu_src_imm=1, -> MEM.
  - BEQ/BNEQ: alu_op=SUB. BGEZ: alu_op=SUB with rt=r0.
  - pc_write=1, pc_src=1 when taken: BEQ on zero, BNEQ on !zero, BGEZ on !neg.
  - All branches -> FETCH.
- MEM:
  - Loads assert mem_read; stores assert mem_write.
  - mem_size: 0 for LB/SB, 1 for LH/SH, 2 for LW/SW.
  - Hold until mem_ready. Store -> FETCH; load -> WB.
- WB: reg_write=1; mem_to_reg=1 for loads. -> FETCH.
- TRAP: all strobes 0; remains until reset.
- retired increments on every transition into FETCH from DECODE, EXEC, MEM or WB. Wraps at 2^CNT_W−1 → 0.
- Outputs are Moore-decoded from state, opcode_q and the flag inputs. Strobes not listed for a state are 0.

## Timing
- Reset (rst_n low at a clk edge): state=FETCH, opcode_q=0, illegal=0, retired=0. All outputs are forced 0 while rst_n is low.
- First cycle after release: mem_read=1.
- Reset mid-instruction aborts it with no further strobes. retired does not count the aborted instruction.
- Cycles per instruction with mem_ready tied 1:
  - jumps 2
  - branches 3
  - ALU 4
  - stores 4
  - loads 5
- Each memory wait cycle adds 1.
- Handshake: mem_read/mem_write, mem_size and the datapath address select stay stable until the cycle mem_ready=1. mem_ready is ignored when no request is asserted.
- zero/neg are sampled in the EXEC cycle only.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode localparams 0x00–0x18
  - the state enum
  - alu_op codes
  - pc_src codes
  - mem_size codes
- Sub-module opcode_class: combinational decode of opcode into {is_rtype, is_itype_alu, is_load, is_store, is_branch, is_jump, illegal, alu_op, mem_size}. multicycle_ctrl instantiates it once on opcode_q, plus the raw opcode in DECODE.

## Test plan
- Reset, then ADD (0x00), mem_ready=1 -> states FETCH, DECODE, EXEC, WB; reg_write only in WB, alu_op=0; retired=1 after 4 cycles.
- LW (0x0D) with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, mem_size=2; WB has mem_to_reg=1; 8 cycles total.
- BEQ (0x13) with zero=1, then zero=0 -> pc_write=1, pc_src=1 in EXEC only for the first; both take 3 cycles.
- JAL (0x17) -> DECODE asserts pc_write, pc_src=2, reg_write, link; next cycle is FETCH.
- Opcode 0x3F -> illegal=1, state TRAP, no strobes for 20 cycles; rst_n low one edge clears illegal and retired.
- Preload retired to 0xFFFF (CNT_W=16), run SW -> retired=0x0000; rst_n low during MEM drops mem_write the same edge.
